// File: rtl/sap_pkg.sv
// Shared encodings for the SAP core: opcodes, sequencer states and their
// one-hot T-state debug view.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_e;

  localparam logic [5:0] T1_OH   = 6'b000001;
  localparam logic [5:0] T2_OH   = 6'b000010;
  localparam logic [5:0] T3_OH   = 6'b000100;
  localparam logic [5:0] T4_OH   = 6'b001000;
  localparam logic [5:0] T5_OH   = 6'b010000;
  localparam logic [5:0] T6_OH   = 6'b100000;
  localparam logic [5:0] HALT_OH = 6'b000000;

  function automatic logic [5:0] tstate_oh(input state_e s);
    logic [5:0] oh;
    oh = HALT_OH;
    case (s)
      ST_T1:   oh = T1_OH;
      ST_T2:   oh = T2_OH;
      ST_T3:   oh = T3_OH;
      ST_T4:   oh = T4_OH;
      ST_T5:   oh = T5_OH;
      ST_T6:   oh = T6_OH;
      default: oh = HALT_OH;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/sap_ram.sv
// Program/data RAM: synchronous write, combinational read. Contents are not
// reset so a loaded program survives clr.
module sap_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap_core_param.sv
// SAP-class CPU core: T1..T6 fetch/execute sequencer, ACC/B datapath with
// C/Z flags, and a RAM that the host fills while run is low.
module sap_core_param
  import sap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [DATA_W-1:0] acc_dbg,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic [1:0]        flags_dbg,
  output logic [5:0]        tstate_dbg
);

  localparam int IR_W = 4 + ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d, b_q, b_d, out_q, out_d;
  logic              c_q, c_d, z_q, z_d, out_valid_q, out_valid_d;
  logic              sta_we;
  logic [DATA_W-1:0] ram_rdata;

  // Only the opcode and operand fields of the fetched word are kept.
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] imm, diff;
  logic [DATA_W:0]   sum;

  assign opcode  = ir_q[IR_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];
  assign imm     = {{(DATA_W-ADDR_W){1'b0}}, operand};
  assign sum     = {1'b0, acc_q} + {1'b0, b_q};
  assign diff    = acc_q - b_q;

  // Load port owns the write side while stopped; STA owns it while running.
  sap_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (!clr && (run ? sta_we : prog_we)),
    .waddr (run ? mar_q : prog_addr),
    .wdata (run ? acc_q : prog_data),
    .raddr (mar_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    b_d         = b_q;
    out_d       = out_q;
    c_d         = c_q;
    z_d         = z_q;
    out_valid_d = 1'b0;
    sta_we      = 1'b0;
    if (!run) begin
      pc_d    = '0;
      state_d = ST_T1;
    end else begin
      case (state_q)
        ST_T1: begin
          mar_d   = pc_q;
          state_d = ST_T2;
        end
        ST_T2: begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_T3;
        end
        ST_T3: begin
          ir_d    = {ram_rdata[DATA_W-1 -: 4], ram_rdata[ADDR_W-1:0]};
          state_d = ST_T4;
        end
        ST_T4: begin
          state_d = ST_T1;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              mar_d   = operand;
              state_d = ST_T5;
            end
            OP_LDI: begin
              acc_d = imm;
              z_d   = (imm == '0);
            end
            OP_JMP: pc_d = operand;
            OP_JC:  if (c_q) pc_d = operand;
            OP_JZ:  if (z_q) pc_d = operand;
            OP_OUT: begin
              out_d       = acc_q;
              out_valid_d = 1'b1;
            end
            OP_HLT:  state_d = ST_HALT;
            default: state_d = ST_T1;
          endcase
        end
        ST_T5: begin
          state_d = ST_T1;
          case (opcode)
            OP_LDA: begin
              acc_d = ram_rdata;
              z_d   = (ram_rdata == '0);
            end
            OP_ADD, OP_SUB: begin
              b_d     = ram_rdata;
              state_d = ST_T6;
            end
            OP_STA:  sta_we = 1'b1;
            default: state_d = ST_T1;
          endcase
        end
        ST_T6: begin
          state_d = ST_T1;
          if (opcode == OP_SUB) begin
            acc_d = diff;
            c_d   = (acc_q >= b_q);
            z_d   = (diff == '0);
          end else begin
            acc_d = sum[DATA_W-1:0];
            c_d   = sum[DATA_W];
            z_d   = (sum[DATA_W-1:0] == '0);
          end
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_T1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_T1;
      pc_q        <= '0;
      mar_q       <= '0;
      ir_q        <= '0;
      acc_q       <= '0;
      b_q         <= '0;
      out_q       <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      out_q       <= out_d;
      c_q         <= c_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data   = out_q;
  assign out_valid  = out_valid_q;
  assign halted     = (state_q == ST_HALT);
  assign acc_dbg    = acc_q;
  assign pc_dbg     = pc_q;
  assign flags_dbg  = {c_q, z_q};
  assign tstate_dbg = tstate_oh(state_q);

endmodule

// File: tb/tb_sap_core_param.sv
// Bench for sap_core_param: an 8/4 instance and a 10/5 instance run the same
// programs; out_valid pulses are scored against an expected queue per instance.
module tb_sap_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, run, prog_we;
  logic [3:0] prog_addr_a;
  logic [7:0] prog_data_a;
  logic [4:0] prog_addr_w;
  logic [9:0] prog_data_w;

  logic [7:0] out_a, acc_a;
  logic [3:0] pc_a;
  logic [9:0] out_w, acc_w;
  logic [4:0] pc_w;
  logic [1:0] fl_a, fl_w;
  logic [5:0] ts_a, ts_w;
  logic       ov_a, ov_w, halt_a, halt_w;

  sap_core_param #(.DATA_W(8), .ADDR_W(4)) dut_a (
    .clk(clk), .clr(clr), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr_a), .prog_data(prog_data_a),
    .out_data(out_a), .out_valid(ov_a), .halted(halt_a), .acc_dbg(acc_a),
    .pc_dbg(pc_a), .flags_dbg(fl_a), .tstate_dbg(ts_a)
  );

  sap_core_param #(.DATA_W(10), .ADDR_W(5)) dut_w (
    .clk(clk), .clr(clr), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr_w), .prog_data(prog_data_w),
    .out_data(out_w), .out_valid(ov_w), .halted(halt_w), .acc_dbg(acc_w),
    .pc_dbg(pc_w), .flags_dbg(fl_w), .tstate_dbg(ts_w)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int run_cyc, first_halt, pulses_a, pulses_w, pulse_cyc_a;
  bit chk_w;
  logic [9:0] exp_q[$];
  logic [9:0] exp_w_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every OUT pulse pops one expected value.
  always @(negedge clk) begin
    if (!clr && ov_a) begin
      pulses_a++;
      pulse_cyc_a = cyc - run_cyc;
      check("sb_a_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("sb_a_out", {2'b00, out_a}, exp_q.pop_front());
    end
    if (!clr && ov_w && chk_w) begin
      pulses_w++;
      check("sb_w_pending", exp_w_q.size() > 0, 1);
      if (exp_w_q.size() > 0) check("sb_w_out", out_w, exp_w_q.pop_front());
    end
  end

  task automatic poke(input int addr, input logic [7:0] d8, input logic [9:0] d10);
    @(negedge clk);
    prog_we     = 1'b1;
    prog_addr_a = addr[3:0];
    prog_addr_w = addr[4:0];
    prog_data_a = d8;
    prog_data_w = d10;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic ins(input int addr, input logic [3:0] op, input int opnd);
    poke(addr, {op, 4'(opnd)}, {op, 6'(opnd)});
  endtask

  task automatic dat(input int addr, input logic [9:0] v);
    poke(addr, v[7:0], v);
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 32; i++) poke(i, 8'h00, 10'h000);
  endtask

  task automatic expect_out(input logic [9:0] v);
    exp_q.push_back(v);
    if (chk_w) exp_w_q.push_back(v);
  endtask

  // Raise run (optionally with prog_we held high) and wait for HLT, bounded.
  task automatic run_prog(input int budget, input bit we_during);
    int n;
    n = 0;
    first_halt = -1;
    pulses_a = 0;
    pulses_w = 0;
    @(negedge clk);
    run = 1'b1;
    run_cyc = cyc;
    if (we_during) begin
      prog_we = 1'b1;
      prog_addr_a = 4'h9;
      prog_addr_w = 5'h09;
      prog_data_a = 8'h77;
      prog_data_w = 10'h077;
    end
    while (n < budget && !(halt_a && (!chk_w || halt_w))) begin
      @(negedge clk);
      n++;
      if (halt_a && first_halt < 0) first_halt = cyc - run_cyc;
    end
    prog_we = 1'b0;
    check("run_budget", n < budget, 1);
    check("sb_a_empty", exp_q.size(), 0);
    if (chk_w) check("sb_w_empty", exp_w_q.size(), 0);
  endtask

  task automatic stop_run();
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc - run_cyc < target) @(negedge clk);
  endtask

  task automatic load_add_prog();
    clear_ram();
    ins(0, 4'h0, 9); ins(1, 4'h1, 10); ins(2, 4'hE, 0); ins(3, 4'hF, 0);
    dat(9, 10'h005); dat(10, 10'h003);
  endtask

  task automatic load_jc_prog(input logic [9:0] a, input logic [9:0] b);
    clear_ram();
    ins(0, 4'h0, 9); ins(1, 4'h1, 10); ins(2, 4'hE, 0); ins(3, 4'h6, 6);
    ins(4, 4'h4, 1); ins(5, 4'hE, 0); ins(6, 4'hF, 0);
    dat(9, a); dat(10, b);
  endtask

  initial begin
    clr = 1'b1; run = 1'b0; prog_we = 1'b0;
    prog_addr_a = '0; prog_data_a = '0; prog_addr_w = '0; prog_data_w = '0;
    chk_w = 1'b1; run_cyc = 0; pulses_a = 0; pulses_w = 0; pulse_cyc_a = -1;
    repeat (3) @(negedge clk);
    check("rst_acc", acc_a, 0);
    check("rst_pc", pc_a, 0);
    check("rst_flags", fl_a, 0);
    check("rst_tstate", ts_a, 6'b000001);
    check("rst_out", out_a, 0);
    check("rst_valid", ov_a, 0);
    check("rst_halted", halt_a, 0);
    check("rst_w_tstate", ts_w, 6'b000001);
    clr = 1'b0;

    // LDA/ADD/OUT/HLT on both widths, with cycle-exact pulse and halt timing
    load_add_prog();
    expect_out(10'h008);
    run_prog(100, 1'b0);
    check("t1_valid_cyc", pulse_cyc_a, 15);
    check("t1_pulses", pulses_a, 1);
    check("t1_halt_cyc", first_halt, 19);
    check("t1_acc", acc_a, 8'h08);
    check("t1_flags", fl_a, 2'b00);
    check("t1_ts_halt", ts_a, 6'b000000);
    check("t1_w_acc", acc_w, 10'h008);
    check("t1_w_flags", fl_w, 2'b00);
    check("t1_w_pulses", pulses_w, 1);
    stop_run();
    check("t1_halt_clears", halt_a, 0);
    check("t1_pc_load", pc_a, 0);

    // SUB borrow/zero cases, ADD carry and JC taken/not taken (8-bit only)
    chk_w = 1'b0;
    clear_ram();
    ins(0, 4'h0, 9); ins(1, 4'h2, 10); ins(2, 4'hE, 0); ins(3, 4'hF, 0);
    dat(9, 10'h003); dat(10, 10'h005);
    expect_out(10'h0FE);
    run_prog(100, 1'b0);
    check("t2_sub_acc", acc_a, 8'hFE);
    check("t2_sub_flags", fl_a, 2'b00);
    stop_run();
    dat(9, 10'h005);
    expect_out(10'h000);
    run_prog(100, 1'b0);
    check("t2_subz_acc", acc_a, 8'h00);
    check("t2_subz_flags", fl_a, 2'b11);
    stop_run();
    load_jc_prog(10'h0FF, 10'h001);
    expect_out(10'h000);
    run_prog(100, 1'b0);
    check("t2_jc_taken_pulses", pulses_a, 1);
    check("t2_carry_flags", fl_a, 2'b11);
    check("t2_carry_acc", acc_a, 8'h00);
    stop_run();
    load_jc_prog(10'h001, 10'h001);
    expect_out(10'h002);
    expect_out(10'h001);
    run_prog(100, 1'b0);
    check("t2_jc_fall_pulses", pulses_a, 2);
    check("t2_jc_fall_flags", fl_a, 2'b00);
    stop_run();

    // Countdown loop on both widths
    chk_w = 1'b1;
    clear_ram();
    ins(0, 4'h4, 3); ins(1, 4'hE, 0); ins(2, 4'h2, 15); ins(3, 4'h3, 14);
    ins(4, 4'h7, 6); ins(5, 4'h5, 1); ins(6, 4'hF, 0);
    dat(15, 10'h001);
    expect_out(10'h003); expect_out(10'h002); expect_out(10'h001);
    run_prog(400, 1'b0);
    check("t3_pulses", pulses_a, 3);
    check("t3_w_pulses", pulses_w, 3);
    check("t3_halted", halt_a, 1);
    check("t3_flags", fl_a, 2'b11);
    check("t3_w_acc", acc_w, 0);
    stop_run();

    // clr during T5 of ADD, then rerun from the untouched RAM
    load_add_prog();
    @(negedge clk);
    run = 1'b1;
    run_cyc = cyc;
    wait_cyc(9);
    check("t4_at_t5", ts_a, 6'b010000);
    check("t4_pre_acc", acc_a, 8'h05);
    clr = 1'b1;
    @(negedge clk);
    check("t4_clr_acc", acc_a, 0);
    check("t4_clr_pc", pc_a, 0);
    check("t4_clr_ts", ts_a, 6'b000001);
    check("t4_clr_out", out_a, 0);
    check("t4_clr_w_acc", acc_w, 0);
    expect_out(10'h008);
    clr = 1'b0;
    begin
      int n;
      n = 0;
      while (n < 100 && !(halt_a && halt_w)) begin
        @(negedge clk);
        n++;
      end
      check("t4_rerun_budget", n < 100, 1);
    end
    check("t4_sb_a_empty", exp_q.size(), 0);
    check("t4_sb_w_empty", exp_w_q.size(), 0);
    stop_run();

    // prog_we ignored while running; RAM value survives for a second run
    chk_w = 1'b0;
    clear_ram();
    ins(0, 4'h0, 9); ins(1, 4'hE, 0); ins(2, 4'hF, 0);
    dat(9, 10'h005);
    expect_out(10'h005);
    run_prog(100, 1'b1);
    stop_run();
    expect_out(10'h005);
    run_prog(100, 1'b0);
    check("t5_we_ignored_acc", acc_a, 8'h05);
    stop_run();

    // All-NOP RAM: PC wraps after 16 instructions of 4 cycles each
    for (int i = 0; i < 16; i++) poke(i, 8'h80, 10'h200);
    @(negedge clk);
    run = 1'b1;
    run_cyc = cyc;
    wait_cyc(14); check("t5_nop_pc4", pc_a, 4);
    wait_cyc(58); check("t5_nop_pc15", pc_a, 15);
    wait_cyc(62); check("t5_nop_wrap", pc_a, 0);
    wait_cyc(63); check("t5_nop_t4", ts_a, 6'b001000);
    wait_cyc(66); check("t5_nop_pc1", pc_a, 1);
    stop_run();

    // STA rewrites the next instruction slot with OUT
    clear_ram();
    ins(0, 4'h0, 8); ins(1, 4'h3, 2); ins(2, 4'hF, 0); ins(3, 4'hF, 0);
    poke(8, 8'hE0, 10'h380);
    expect_out(10'h0E0);
    run_prog(100, 1'b0);
    check("t5_selfmod_pulses", pulses_a, 1);
    stop_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
